alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit add/sub ALU. Scales to WIDTH bits and widens the operation set to eight ops, including an iterative shift-add multiply. Adds a valid/ready handshake on input and output, an accumulator operand, and a full flag set. Sits between the datapath controller and the register file as the execute stage.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).
MUL_EN, 1, 1 = MUL op implemented; 0 = MUL op is illegal (err flag set, result 0).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request this cycle
op  in  3  operation code (see Behaviour)
a  in  WIDTH  operand A (ignored when use_acc=1)
b  in  WIDTH  operand B
use_acc  in  1  1 = take operand A from the accumulator
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
s  out  WIDTH  result
overflow  out  1  signed overflow (ADD/SUB); upper product half nonzero (MUL)
carry  out  1  unsigned carry-out (ADD); borrow (SUB); 0 otherwise
zero  out  1  s == 0
negative  out  1  s[WIDTH-1]
err  out  1  illegal op (MUL with MUL_EN=0)
busy  out  1  multiply in progress
acc  out  WIDTH  current accumulator value

Behaviour:
- Reset (async, any time, including mid-multiply): state IDLE; s, acc, all flags, out_valid, busy = 0. Any in-flight op is discarded. in_ready = 1 on the first cycle after reset release.
- Op codes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 SLT (signed a<b -> 1, else 0); 110 MUL (unsigned, low WIDTH bits of product); 111 CLR (s=0, acc cleared).
- in_ready = (state==IDLE) && (!out_valid || out_ready). A request is accepted when in_valid && in_ready. Operands are sampled at that edge.
- FSM states:
  - IDLE -> IDLE for single-cycle ops: result/flags registered at the accept edge; out_valid=1 from the next cycle.
  - IDLE -> MUL on MUL accept (MUL_EN=1): busy=1; WIDTH shift-add iterations, one per clock. On the last iteration the result is registered and the FSM returns to IDLE, so out_valid rises WIDTH cycles after accept.
- Output register is one deep. While out_valid && !out_ready, s, flags and err stay stable. out_valid falls on the out handshake unless a new result is registered on the same edge. Back-to-back single-cycle ops sustain 1 result per cycle when out_ready=1.
- acc loads s on every edge where a new result is registered (CLR loads 0). use_acc reads acc as of the accept edge, so a dependent op issued the cycle after the result sees the new value.
- Flags:
  - ADD/SUB: overflow = signed overflow, identical to the legacy 4-bit rule at WIDTH=4; carry = carry/borrow out of bit WIDTH-1.
  - MUL: overflow = |product[2W-1:W], carry = 0.
  - Logic ops, SLT, CLR: overflow = carry = 0.
  - zero and negative are always computed from s.
- err: set only for op 110 with MUL_EN=0. In that case the op completes as single-cycle, s=0, acc is unchanged, zero=1. err=0 for every other result.
- Simultaneous events:
  - in_valid during MUL is ignored (in_ready=0).
  - out_ready without out_valid has no effect.
  - An out handshake and a new accept on the same edge is legal and required.

Decomposition:
- Package alu_pkg: op code localparams (OP_ADD..OP_CLR), FSM state encoding (ST_IDLE, ST_MUL), and a flag-vector index constant set.
- One sub-module, alu_core: combinational WIDTH-parameterised ADD/SUB/logic/SLT datapath with overflow/carry. It is reused by the multiplier iteration for its adds.
- The FSM, multiplier registers, output register and accumulator live in alu_seq.

Test Plan:
- WIDTH=4: ADD a=7, b=1 -> s=4'h8, overflow=1, carry=0, negative=1, out_valid 1 cycle after accept.
- WIDTH=4: SUB a=0, b=1 -> s=4'hF, carry(borrow)=1, overflow=0, negative=1. Then SUB a=8, b=1 -> s=4'h7, overflow=1.
- WIDTH=4 MUL 5*3 -> s=4'hF, overflow=0, busy for 4 cycles, in_ready=0 throughout. MUL 6*3 -> s=4'h2, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles after ADD 2+3 -> s=5 held stable, in_ready=0. Release -> handshake, next op accepted on the same edge.
- Accumulator chain (WIDTH=8): CLR, then ADD use_acc=1 b=10 three times back-to-back -> s=10, 20, 30 on consecutive cycles, acc=30.
- Assert rst mid-MUL (WIDTH=8, 3rd iteration) -> all outputs 0 asynchronously. After release, ADD 1+1 -> s=2 with no residue from the aborted op. Separately, MUL_EN=0 with op=110 -> err=1, s=0, acc unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and flag-vector layout for the execute-stage ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  localparam int FLG_OV  = 0;
  localparam int FLG_CY  = 1;
  localparam int FLG_Z   = 2;
  localparam int FLG_N   = 3;
  localparam int FLG_ERR = 4;
  localparam int FLG_W   = 5;
endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the execute-stage ALU; master issues ops, slave is the ALU.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, use_acc, out_ready,
    input  in_ready, out_valid, s, overflow, carry, zero, negative, err, busy, acc
  );
  modport slave (
    input  in_valid, op, a, b, use_acc, out_ready,
    output in_ready, out_valid, s, overflow, carry, zero, negative, err, busy, acc
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ADD/SUB/logic/SLT datapath with signed overflow and carry/borrow.
// Zero latency, no flow control; MUL and CLR codes yield zero with flags clear.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             carry
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           ov_add;
  logic           ov_sub;
  logic           lt;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign ov_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ov_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Signed less-than: sign of the difference, corrected when the subtraction overflowed.
  assign lt     = diff[WIDTH-1] ^ ov_sub;

  always_comb begin
    y        = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (op)
      OP_ADD: begin
        y        = sum[WIDTH-1:0];
        overflow = ov_add;
        carry    = sum[WIDTH];
      end
      OP_SUB: begin
        y        = diff[WIDTH-1:0];
        overflow = ov_sub;
        carry    = diff[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: 1-cycle ops, WIDTH-cycle shift-add MUL, accumulator operand.
// One-deep output register; in_ready drops while MUL runs or an unread result is stalled.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic   clk,
  input logic   rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic             can_accept, accept, is_mul;
  logic             mul_go, load, acc_load;
  logic [WIDTH-1:0] op_a;
  logic [2:0]       core_op;
  logic [WIDTH-1:0] core_a, core_b, core_y;
  logic             core_ov, core_cy;
  logic [WIDTH-1:0] mcand, prod_hi, prod_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_q, acc_q, s_nxt;
  logic [FLG_W-1:0] flg_q, flg_nxt;
  logic             out_valid_q;

  assign can_accept = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && can_accept;
  assign is_mul     = (bus.op == OP_MUL);
  assign op_a       = bus.use_acc ? acc_q : bus.a;

  // The multiplier borrows the core adder: partial product into the running high half.
  always_comb begin
    if (state == ST_MUL) begin
      core_op = OP_ADD;
      core_a  = prod_hi;
      core_b  = prod_lo[0] ? mcand : '0;
    end else begin
      core_op = bus.op;
      core_a  = op_a;
      core_b  = bus.b;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (core_op),
    .a        (core_a),
    .b        (core_b),
    .y        (core_y),
    .overflow (core_ov),
    .carry    (core_cy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_go    = 1'b0;
    load      = 1'b0;
    acc_load  = 1'b0;
    s_nxt     = core_y;
    flg_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul && MUL_EN) begin
            mul_go    = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            load             = 1'b1;
            acc_load         = !is_mul;
            flg_nxt[FLG_OV]  = core_ov;
            flg_nxt[FLG_CY]  = core_cy;
            flg_nxt[FLG_ERR] = is_mul;
          end
        end
      end
      ST_MUL: begin
        if (cnt == CW'(WIDTH - 1)) begin
          load            = 1'b1;
          acc_load        = 1'b1;
          s_nxt           = {core_y[0], prod_lo[WIDTH-1:1]};
          flg_nxt[FLG_OV] = |{core_cy, core_y[WIDTH-1:1]};
          state_nxt       = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    flg_nxt[FLG_Z] = (s_nxt == '0);
    flg_nxt[FLG_N] = s_nxt[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand       <= '0;
      prod_hi     <= '0;
      prod_lo     <= '0;
      cnt         <= '0;
      s_q         <= '0;
      flg_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (mul_go) begin
        mcand   <= op_a;
        prod_hi <= '0;
        prod_lo <= bus.b;
        cnt     <= '0;
      end else if (state == ST_MUL) begin
        {prod_hi, prod_lo} <= {core_cy, core_y, prod_lo[WIDTH-1:1]};
        cnt                <= cnt + 1'b1;
      end
      if (load) begin
        s_q         <= s_nxt;
        flg_q       <= flg_nxt;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (acc_load) acc_q <= s_nxt;
    end
  end

  assign bus.in_ready  = can_accept;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.overflow  = flg_q[FLG_OV];
  assign bus.carry     = flg_q[FLG_CY];
  assign bus.zero      = flg_q[FLG_Z];
  assign bus.negative  = flg_q[FLG_N];
  assign bus.err       = flg_q[FLG_ERR];
  assign bus.busy      = (state == ST_MUL);
  assign bus.acc       = acc_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq at WIDTH=4, WIDTH=8 and WIDTH=8 without multiplier.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic ov, cy, z, n, e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(4)) b4 ();
  alu_seq_if #(.WIDTH(8)) b8 ();
  alu_seq_if #(.WIDTH(8)) bn ();

  alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) u4 (.clk(clk), .rst(rst), .bus(b4));
  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u8 (.clk(clk), .rst(rst), .bus(b8));
  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) un (.clk(clk), .rst(rst), .bus(bn));

  int         errors = 0;
  int         checks = 0;
  exp_t       q4[$];
  exp_t       q8[$];
  exp_t       qn[$];
  logic [7:0] macc8 = 8'h0;
  logic [7:0] maccn = 8'h0;

  function automatic exp_t model(input int w, input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input bit mul_en);
    exp_t r;
    int ua, ub, sa, sb, res, mask, half;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= half) ? ua - (1 << w) : ua;
    sb = (ub >= half) ? ub - (1 << w) : ub;
    r = '0;
    case (op)
      3'd0: begin
        res  = ua + ub;
        r.s  = 8'(res & mask);
        r.cy = (res > mask);
        r.ov = (sa + sb > half - 1) || (sa + sb < -half);
      end
      3'd1: begin
        res  = ua - ub;
        r.s  = 8'(res & mask);
        r.cy = (ua < ub);
        r.ov = (sa - sb > half - 1) || (sa - sb < -half);
      end
      3'd2: r.s = a & b;
      3'd3: r.s = a | b;
      3'd4: r.s = a ^ b;
      3'd5: r.s = (sa < sb) ? 8'd1 : 8'd0;
      3'd6: begin
        if (mul_en) begin
          res  = ua * ub;
          r.s  = 8'(res & mask);
          r.ov = ((res >> w) != 0);
        end else begin
          r.e = 1'b1;
        end
      end
      default: r.s = 8'h0;
    endcase
    r.z = (r.s == 8'h0);
    r.n = r.s[w-1];
    return r;
  endfunction

  function automatic exp_t obs4();
    exp_t o;
    o = {{4'h0, b4.s}, b4.overflow, b4.carry, b4.zero, b4.negative, b4.err};
    return o;
  endfunction

  function automatic exp_t obs8();
    exp_t o;
    o = {b8.s, b8.overflow, b8.carry, b8.zero, b8.negative, b8.err};
    return o;
  endfunction

  function automatic exp_t obsn();
    exp_t o;
    o = {bn.s, bn.overflow, bn.carry, bn.zero, bn.negative, bn.err};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b4.in_valid = 1'b0; b4.op = 3'd0; b4.a = '0; b4.b = '0; b4.use_acc = 1'b0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.op = 3'd0; b8.a = '0; b8.b = '0; b8.use_acc = 1'b0; b8.out_ready = 1'b1;
    bn.in_valid = 1'b0; bn.op = 3'd0; bn.a = '0; bn.b = '0; bn.use_acc = 1'b0; bn.out_ready = 1'b1;
  endtask

  task automatic send4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    b4.in_valid = 1'b1; b4.op = op; b4.a = a; b4.b = b; b4.use_acc = 1'b0;
    q4.push_back(model(4, op, {4'h0, a}, {4'h0, b}, 1'b1));
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
    exp_t e;
    b8.in_valid = 1'b1; b8.op = op; b8.a = a; b8.b = b; b8.use_acc = ua;
    e = model(8, op, ua ? macc8 : a, b, 1'b1);
    if (!e.e) macc8 = e.s;
    q8.push_back(e);
  endtask

  task automatic sendn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bn.in_valid = 1'b1; bn.op = op; bn.a = a; bn.b = b; bn.use_acc = 1'b0;
    e = model(8, op, a, b, 1'b0);
    if (!e.e) maccn = e.s;
    qn.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({b4.out_valid, b4.busy, b4.s, b4.acc, b4.overflow, b4.carry, b4.zero, b4.negative, b4.err} !== '0) begin
      errors++; $display("FAIL reset_w4 got s=%h acc=%h vld=%b", b4.s, b4.acc, b4.out_valid);
    end
    checks++;
    if ({b8.out_valid, b8.busy, b8.s, b8.acc, b8.overflow, b8.carry, b8.zero, b8.negative, b8.err} !== '0) begin
      errors++; $display("FAIL reset_w8 got s=%h acc=%h vld=%b", b8.s, b8.acc, b8.out_valid);
    end
    checks++;
    if ({bn.out_valid, bn.busy, bn.s, bn.acc, bn.overflow, bn.carry, bn.zero, bn.negative, bn.err} !== '0) begin
      errors++; $display("FAIL reset_nomul got s=%h acc=%h vld=%b", bn.s, bn.acc, bn.out_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({b4.in_ready, b8.in_ready, bn.in_ready} !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready got %b need 111", {b4.in_ready, b8.in_ready, bn.in_ready});
    end
  endtask

  task automatic test_add();
    exp_t e, o;
    send4(OP_ADD, 4'd7, 4'd1);
    tick();
    b4.in_valid = 1'b0;
    checks++;
    if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid=%b need 1", b4.out_valid); end
    e = q4.pop_front(); o = obs4();
    checks++;
    if (o !== e) begin errors++; $display("FAIL add_7_1 got=%h need=%h", o, e); end
    checks++;
    if ({b4.s, b4.overflow, b4.carry, b4.negative} !== {4'h8, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_7_1_const got s=%h ov=%b cy=%b n=%b", b4.s, b4.overflow, b4.carry, b4.negative);
    end
    tick();
    checks++;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain out_valid=%b need 0", b4.out_valid); end
  endtask

  task automatic test_sub();
    exp_t e, o;
    logic [3:0] ta [2] = '{4'd0, 4'd8};
    logic [3:0] tb [2] = '{4'd1, 4'd1};
    for (int i = 0; i < 2; i++) begin
      send4(OP_SUB, ta[i], tb[i]);
      tick();
      checks++;
      if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid[%0d] out_valid=%b need 1", i, b4.out_valid); end
      e = q4.pop_front(); o = obs4();
      checks++;
      if (o !== e) begin errors++; $display("FAIL sub[%0d] got=%h need=%h", i, o, e); end
    end
    b4.in_valid = 1'b0;
    checks++;
    if ({b4.s, b4.overflow, b4.carry} !== {4'h7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_8_1_const got s=%h ov=%b cy=%b", b4.s, b4.overflow, b4.carry);
    end
    tick();
  endtask

  task automatic test_mul();
    exp_t e, o;
    logic [3:0] ma [2] = '{4'd5, 4'd6};
    for (int i = 0; i < 2; i++) begin
      send4(OP_MUL, ma[i], 4'd3);
      tick();
      b4.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({b4.busy, b4.in_ready, b4.out_valid} !== 3'b100) begin
          errors++; $display("FAIL mul_busy[%0d.%0d] busy/rdy/vld=%b need 100", i, c, {b4.busy, b4.in_ready, b4.out_valid});
        end
        if (c == 0) begin b4.in_valid = 1'b1; b4.op = OP_ADD; b4.a = 4'd1; b4.b = 4'd1; end
        if (c == 2) b4.in_valid = 1'b0;
        tick();
      end
      checks++;
      if ({b4.out_valid, b4.busy} !== 2'b10) begin
        errors++; $display("FAIL mul_done[%0d] vld/busy=%b need 10", i, {b4.out_valid, b4.busy});
      end
      e = q4.pop_front(); o = obs4();
      checks++;
      if (o !== e) begin errors++; $display("FAIL mul[%0d] got=%h need=%h", i, o, e); end
    end
    tick();
    checks++;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL mul_ignored out_valid=%b need 0", b4.out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t e, o;
    b4.out_ready = 1'b0;
    send4(OP_ADD, 4'd2, 4'd3);
    tick();
    send4(OP_XOR, 4'd5, 4'd3);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({b4.out_valid, b4.in_ready, b4.s} !== {1'b1, 1'b0, 4'd5}) begin
        errors++; $display("FAIL bp_hold[%0d] vld=%b rdy=%b s=%h need 1 0 5", c, b4.out_valid, b4.in_ready, b4.s);
      end
      tick();
    end
    b4.out_ready = 1'b1;
    #1;
    checks++;
    if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready=%b need 1", b4.in_ready); end
    e = q4.pop_front(); o = obs4();
    checks++;
    if (o !== e) begin errors++; $display("FAIL bp_add got=%h need=%h", o, e); end
    tick();
    b4.in_valid = 1'b0;
    checks++;
    if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid out_valid=%b need 1", b4.out_valid); end
    e = q4.pop_front(); o = obs4();
    checks++;
    if (o !== e) begin errors++; $display("FAIL bp_xor got=%h need=%h", o, e); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int k;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 6);
      send4((k == 6) ? OP_CLR : 3'(k), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      checks++;
      if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] out_valid=%b need 1", i, b4.out_valid); end
      e = q4.pop_front(); o = obs4();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b[%0d] op=%0d got=%h need=%h", i, b4.op, o, e); end
    end
    b4.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_acc_chain();
    exp_t e, o;
    send8(OP_CLR, 8'd0, 8'd0, 1'b0);
    tick();
    e = q8.pop_front(); o = obs8();
    checks++;
    if (o !== e) begin errors++; $display("FAIL acc_clr got=%h need=%h", o, e); end
    for (int i = 0; i < 3; i++) begin
      send8(OP_ADD, 8'd0, 8'd10, 1'b1);
      tick();
      e = q8.pop_front(); o = obs8();
      checks++;
      if (o !== e || b8.out_valid !== 1'b1) begin
        errors++; $display("FAIL acc_add[%0d] vld=%b got=%h need=%h", i, b8.out_valid, o, e);
      end
      checks++;
      if (b8.s !== 8'(10 * (i + 1))) begin errors++; $display("FAIL acc_add_const[%0d] s=%0d need %0d", i, b8.s, 10 * (i + 1)); end
    end
    b8.in_valid = 1'b0;
    b8.use_acc = 1'b0;
    checks++;
    if (b8.acc !== 8'd30) begin errors++; $display("FAIL acc_final acc=%0d need 30", b8.acc); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    exp_t e, o;
    send8(OP_MUL, 8'd200, 8'd3, 1'b0);
    tick();
    b8.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({b8.out_valid, b8.busy, b8.s, b8.acc, b8.overflow, b8.carry, b8.zero, b8.negative, b8.err} !== '0) begin
      errors++; $display("FAIL rst_mid_mul busy=%b acc=%h s=%h need all 0", b8.busy, b8.acc, b8.s);
    end
    q8.delete();
    macc8 = 8'h0;
    maccn = 8'h0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({b8.out_valid, b8.in_ready, b8.busy} !== 3'b010) begin
      errors++; $display("FAIL rst_release vld/rdy/busy=%b need 010", {b8.out_valid, b8.in_ready, b8.busy});
    end
    send8(OP_ADD, 8'd1, 8'd1, 1'b0);
    tick();
    b8.in_valid = 1'b0;
    e = q8.pop_front(); o = obs8();
    checks++;
    if (o !== e || b8.out_valid !== 1'b1 || b8.acc !== 8'd2) begin
      errors++; $display("FAIL rst_add vld=%b acc=%h got=%h need=%h", b8.out_valid, b8.acc, o, e);
    end
    tick();
  endtask

  task automatic test_err();
    exp_t e, o;
    sendn(OP_ADD, 8'd5, 8'd7);
    tick();
    e = qn.pop_front(); o = obsn();
    checks++;
    if (o !== e) begin errors++; $display("FAIL err_prime got=%h need=%h", o, e); end
    sendn(OP_MUL, 8'd3, 8'd4);
    tick();
    bn.in_valid = 1'b0;
    checks++;
    if ({bn.out_valid, bn.busy} !== 2'b10) begin errors++; $display("FAIL err_single_cycle vld/busy=%b need 10", {bn.out_valid, bn.busy}); end
    e = qn.pop_front(); o = obsn();
    checks++;
    if (o !== e) begin errors++; $display("FAIL err_mul got=%h need=%h", o, e); end
    checks++;
    if ({bn.err, bn.s, bn.zero, bn.acc} !== {1'b1, 8'h0, 1'b1, 8'd12}) begin
      errors++; $display("FAIL err_const err=%b s=%h z=%b acc=%0d need 1 00 1 12", bn.err, bn.s, bn.zero, bn.acc);
    end
    tick();
    sendn(OP_ADD, 8'd1, 8'd2);
    tick();
    bn.in_valid = 1'b0;
    e = qn.pop_front(); o = obsn();
    checks++;
    if (o !== e || bn.acc !== 8'd3) begin errors++; $display("FAIL err_clear acc=%0d got=%h need=%h", bn.acc, o, e); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_acc_chain();
    test_reset_mid_mul();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
